// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/busy/done handshake.
//   Single-cycle arithmetic/logic ops complete on the start edge.
//   MUL (unsigned shift-add) and SHL/SHR (one bit per edge) iterate in ITER.
//   R/RH/flags change only when an op completes and hold until the next one.
//
// Ports:
//   clk, reset           clock (rising edge), async active-high reset
//   start, op, A, B, c_in request and operands, sampled only while not busy
//   R, RH                result; RH is the product high half (0 unless MUL)
//   zero, c_out, sign, ovf  registered flags
//   busy, done           iteration in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// ITER  | MUL or shift stepping, cnt_q counts remaining edges down to 1
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] RH,
  output logic             zero,
  output logic             c_out,
  output logic             sign,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("alu_seq: WIDTH must be a power of two and >= 4");
  end

  typedef enum logic {IDLE, ITER} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;     // multiplicand for MUL, working shift register for SHL/SHR
  logic [2*WIDTH-1:0] acc_q; // {partial high, remaining multiplier bits}
  logic             is_mul_q;
  logic             shr_q;
  logic [CW-1:0]    cnt_q;

  logic [CW-1:0]    shamt;
  logic             is_mul_op;
  logic             is_shift_op;

  assign shamt       = {1'b0, B[SHW-1:0]};
  assign is_mul_op   = !op[3] && (op[2:0] == 3'b101);
  assign is_shift_op = !op[3] && (op[2:1] == 2'b11) && (shamt != '0);

  // Single-cycle datapath
  logic [WIDTH-1:0] op1, op2, res;
  logic [WIDTH:0]   sum;
  logic             ci, cout, ov;

  always_comb begin
    op1  = A;
    op2  = '0;
    ci   = c_in;
    sum  = '0;
    res  = A;
    cout = 1'b0;
    ov   = 1'b0;
    if (!op[3]) begin
      case (op[2:0])
        3'b001: begin op1 = ~A; op2 = WIDTH'(1); end
        3'b010: op2 = B;
        3'b011: op2 = WIDTH'(1);
        3'b100: begin op2 = ~B; ci = 1'b1; end
        default: ;
      endcase
      sum = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, ci};
      if (op[2:0] <= 3'b100) begin
        res  = sum[WIDTH-1:0];
        cout = sum[WIDTH];
        ov   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
      end
      // zero-amount shifts fall through with res = A, c_out = 0
    end else begin
      case (op[2:0])
        3'b000:  res = A & B;
        3'b001:  res = A | B;
        3'b010:  res = A ^ B;
        3'b011:  res = ~A;
        default: res = A;
      endcase
    end
  end

  // One iteration step. MUL adds the multiplicand into the high half when the
  // current multiplier bit is set, then shifts the whole accumulator right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   sh_next;
  logic               sh_out;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    sh_next  = shr_q ? {1'b0, a_q[WIDTH-1:1]} : {a_q[WIDTH-2:0], 1'b0};
    sh_out   = shr_q ? a_q[0] : a_q[WIDTH-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_q      <= '0;
      acc_q    <= '0;
      is_mul_q <= 1'b0;
      shr_q    <= 1'b0;
      cnt_q    <= '0;
      R        <= '0;
      RH       <= '0;
      zero     <= 1'b0;
      c_out    <= 1'b0;
      sign     <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul_op) begin
              a_q      <= A;
              acc_q    <= {{WIDTH{1'b0}}, B};
              is_mul_q <= 1'b1;
              cnt_q    <= CW'(WIDTH);
              busy     <= 1'b1;
              state    <= ITER;
            end else if (is_shift_op) begin
              a_q      <= A;
              is_mul_q <= 1'b0;
              shr_q    <= op[0];
              cnt_q    <= shamt;
              busy     <= 1'b1;
              state    <= ITER;
            end else begin
              R     <= res;
              RH    <= '0;
              zero  <= (res == '0);
              sign  <= res[WIDTH-1];
              c_out <= cout;
              ovf   <= ov;
              done  <= 1'b1;
            end
          end
        end
        ITER: begin
          cnt_q <= cnt_q - 1'b1;
          if (is_mul_q) acc_q <= mul_next;
          else          a_q   <= sh_next;
          if (cnt_q == CW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            ovf   <= 1'b0;
            state <= IDLE;
            if (is_mul_q) begin
              R     <= mul_next[WIDTH-1:0];
              RH    <= mul_next[2*WIDTH-1:WIDTH];
              zero  <= (mul_next == '0);
              sign  <= mul_next[2*WIDTH-1];
              c_out <= 1'b0;
            end else begin
              R     <= sh_next;
              RH    <= '0;
              zero  <= (sh_next == '0);
              sign  <= sh_next[WIDTH-1];
              c_out <= sh_out;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] op;
  logic [7:0] A, B;
  logic       c_in;
  logic [7:0] R, RH;
  logic       zero, c_out, sign, ovf, busy, done;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B), .c_in(c_in),
    .R(R), .RH(RH), .zero(zero), .c_out(c_out), .sign(sign), .ovf(ovf),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] r, rh;
    logic       z, c, s, v;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: pops an expectation for every done pulse.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (prev_done) begin
        checks++; failures++;
        $display("FAIL done_width: done high on consecutive cycles at cycle %0d, required single pulse", cycle);
      end
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: done at cycle %0d with R=%h, required no done", cycle, R);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if ({R, RH, zero, c_out, sign, ovf} !== {e.r, e.rh, e.z, e.c, e.s, e.v}) begin
          failures++;
          $display("FAIL %s_result: got R=%h RH=%h z=%b c=%b s=%b v=%b, required R=%h RH=%h z=%b c=%b s=%b v=%b",
                   e.name, R, RH, zero, c_out, sign, ovf, e.r, e.rh, e.z, e.c, e.s, e.v);
        end
        checks++;
        if (cycle != e.cyc) begin
          failures++;
          $display("FAIL %s_latency: done at cycle %0d, required cycle %0d", e.name, cycle, e.cyc);
        end
      end
    end
    prev_done = done;
  end

  // Drive a request at a negedge; the next posedge is the start edge.
  task automatic issue(input string name, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic push, input int lat,
                       input logic [7:0] er, input logic [7:0] erh,
                       input logic ez, input logic ec, input logic es, input logic ev);
    exp_t e;
    @(negedge clk);
    op = o; A = a; B = b; c_in = ci; start = 1'b1;
    if (push) begin
      e.name = name; e.r = er; e.rh = erh; e.z = ez; e.c = ec; e.s = es; e.v = ev;
      e.cyc = cycle + 1 + lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 8'h5A; B = 8'h00; c_in = 1'b0; op = 4'b1011;  // operands must already be latched
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d results outstanding after %0d cycles, required 0", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  initial begin
    int busy_n;
    start = 1'b0; op = 4'd0; A = 8'd0; B = 8'd0; c_in = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({R, RH, zero, c_out, sign, ovf, busy, done} !== 22'd0) begin
      failures++;
      $display("FAIL reset_state: got R=%h RH=%h flags=%b%b%b%b busy=%b done=%b, required all 0",
               R, RH, zero, c_out, sign, ovf, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // ADD F0+20+1
    issue("add", 4'b0010, 8'hF0, 8'h20, 1'b1, 1'b1, 0, 8'h11, 8'h00, 0, 1, 0, 0);
    @(negedge clk);
    check_bit("add_busy", busy, 1'b0);
    wait_drain("add");

    // SUB 80-01
    issue("sub", 4'b0100, 8'h80, 8'h01, 1'b1, 1'b1, 0, 8'h7F, 8'h00, 0, 1, 0, 1);
    wait_drain("sub");

    // NEG 01 -> FF
    issue("neg", 4'b0001, 8'h01, 8'h00, 1'b0, 1'b1, 0, 8'hFF, 8'h00, 0, 0, 1, 0);
    wait_drain("neg");

    // MUL FF*FF with an ignored start mid-op
    issue("mul", 4'b0101, 8'hFF, 8'hFF, 1'b0, 1'b1, 8, 8'h01, 8'hFE, 0, 0, 1, 0);
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (i == 3) begin
        op = 4'b0010; A = 8'h55; B = 8'h01; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (busy_n != 8) begin
      failures++;
      $display("FAIL mul_busy_cycles: got %0d, required 8", busy_n);
    end
    wait_drain("mul");

    // Shifts
    issue("shl3", 4'b0110, 8'h81, 8'h03, 1'b0, 1'b1, 3, 8'h08, 8'h00, 0, 0, 0, 0);
    wait_drain("shl3");
    issue("shl0", 4'b0110, 8'h80, 8'h00, 1'b0, 1'b1, 0, 8'h80, 8'h00, 0, 0, 1, 0);
    wait_drain("shl0");
    issue("shr1", 4'b0111, 8'h81, 8'h01, 1'b0, 1'b1, 1, 8'h40, 8'h00, 0, 1, 0, 0);
    wait_drain("shr1");

    // Reset abort during MUL (outputs currently hold SHR result)
    issue("mul_abort", 4'b0101, 8'h12, 8'h34, 1'b0, 1'b0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    check_bit("abort_busy_before", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({R, RH, zero, c_out, sign, ovf, busy, done} !== 22'd0) begin
      failures++;
      $display("FAIL abort_reset: got R=%h RH=%h flags=%b%b%b%b busy=%b done=%b, required all 0",
               R, RH, zero, c_out, sign, ovf, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check_bit("abort_busy_after", busy, 1'b0);

    issue("add_after_rst", 4'b0010, 8'h01, 8'h01, 1'b0, 1'b1, 0, 8'h02, 8'h00, 0, 0, 0, 0);
    wait_drain("add_after_rst");

    // Logic ops
    issue("xor", 4'b1010, 8'hAA, 8'hAA, 1'b1, 1'b1, 0, 8'h00, 8'h00, 1, 0, 0, 0);
    wait_drain("xor");
    issue("and", 4'b1000, 8'hF0, 8'h3C, 1'b0, 1'b1, 0, 8'h30, 8'h00, 0, 0, 0, 0);
    wait_drain("and");
    issue("not", 4'b1011, 8'h0F, 8'h00, 1'b0, 1'b1, 0, 8'hF0, 8'h00, 0, 0, 1, 0);
    wait_drain("not");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
